// File: rtl/mux_scan_n.sv
// Registered N-channel multiplexer with manual select, auto-scan with dwell
// time, hold control and one-cycle status pulses (ch_change, wrap, sel_err).
module mux_scan_n #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 4,
  parameter int DWELL = 3,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  input  logic                  hold,
  output logic [WIDTH-1:0]      out,
  output logic [SEL_W-1:0]      cur_sel,
  output logic                  ch_change,
  output logic                  wrap,
  output logic                  sel_err
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [SEL_W-1:0] sel_next;
  logic             wrap_next;
  logic             err_next;
  logic [WIDTH-1:0] ch [N_CH];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign ch[gi] = data_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // mode is sampled every edge; the first mode=1 edge only enters SCAN and
  // clears the dwell counter so the current channel gets a full dwell.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    sel_next   = cur_sel;
    wrap_next  = 1'b0;
    err_next   = 1'b0;
    if (!mode) begin
      state_next = MANUAL;
      if (int'(sel) < N_CH) begin
        sel_next = sel;
      end else begin
        err_next = 1'b1;
      end
    end else if (state_reg == MANUAL) begin
      state_next = SCAN;
    end else if (hold) begin
      cnt_next = cnt_reg;
    end else if (cnt_reg == CNT_LAST) begin
      if (cur_sel == LAST_CH) begin
        sel_next  = '0;
        wrap_next = 1'b1;
      end else begin
        sel_next = cur_sel + 1'b1;
      end
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // out and cur_sel load from the same sel_next so they always agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= MANUAL;
      cnt_reg   <= '0;
      cur_sel   <= '0;
      out       <= '0;
      ch_change <= 1'b0;
      wrap      <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cur_sel   <= sel_next;
      out       <= ch[sel_next];
      ch_change <= (sel_next != cur_sel);
      wrap      <= wrap_next;
      sel_err   <= err_next;
    end
  end

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised, registered N-channel multiplexer. It succeeds the combinational 4:1, 4-bit mux.
- Adds:
  - configurable channel count and width;
  - a manual-select mode;
  - an auto-scan mode that steps through the channels with a programmable dwell time;
  - a hold control;
  - status pulses.
- Intended for time-multiplexed display/readout paths, e.g. 7-segment digit scanning, and for channel sweeping in lab designs.

Parameters:
- N_CH, 4, number of input channels (>= 2).
- WIDTH, 4, bits per channel.
- DWELL, 3, clock cycles each channel is held in auto mode (>= 1).
- SEL_W, $clog2(N_CH), width of the select signals. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  N_CH*WIDTH  flattened channels; channel i = data_in[i*WIDTH +: WIDTH].
- sel  in  SEL_W  manual channel select.
- mode  in  1  0 = manual, 1 = auto-scan.
- hold  in  1  freezes channel advance in auto mode.
- out  out  WIDTH  registered selected channel data.
- cur_sel  out  SEL_W  registered index of the channel currently driven on out.
- ch_change  out  1  one-cycle pulse when cur_sel changed on the last edge.
- wrap  out  1  one-cycle pulse when auto-scan wrapped from N_CH-1 to 0.
- sel_err  out  1  one-cycle pulse when a manual sel >= N_CH was rejected.

Behaviour:
- Single clock domain. One clock; reset is synchronous and active-high.
- While reset=1 at a rising edge:
  - out=0, cur_sel=0, ch_change=0, wrap=0, sel_err=0;
  - dwell counter cnt=0; state=MANUAL.
  - out is 0 after reset, not data_in[0], until the first non-reset edge.
- Each edge computes sel_nxt, then updates cur_sel<=sel_nxt and out<=data_in[sel_nxt] together. out therefore always equals the channel named by cur_sel, sampled at the same edge. Latency from data_in/sel to out is 1 cycle.
- out refreshes every non-reset edge in both modes and under hold, so data changes on a frozen channel still propagate with 1-cycle latency.
- State MANUAL (mode=0):
  - If sel < N_CH: sel_nxt = sel.
  - Otherwise: sel_nxt = cur_sel and sel_err=1 for one cycle. This only applies when N_CH is not a power of 2.
  - cnt is held at 0.
- State SCAN (mode=1):
  - If hold=1: cnt and cur_sel are frozen.
  - Else if cnt == DWELL-1: cnt<=0 and sel_nxt = cur_sel+1. When cur_sel == N_CH-1, sel_nxt = 0 and wrap=1 for one cycle.
  - Else: cnt<=cnt+1 and sel_nxt = cur_sel.
- State transitions (mode is sampled each edge):
  - MANUAL→SCAN: cnt<=0; scanning starts from the current cur_sel. That channel dwells DWELL full cycles before advancing; no jump to 0.
  - SCAN→MANUAL: sel is applied on the same edge at which mode=0 is first sampled; cnt<=0.
- ch_change=1 for the cycle after any edge where sel_nxt != the previous cur_sel. This covers manual changes, auto advances and wraps. A rejected sel or an unchanged sel gives 0.
- DWELL=1: advances every cycle; wrap pulses every N_CH cycles.
- Simultaneous events:
  - hold=1 exactly at a dwell expiry suppresses the advance. It resumes on the first edge with hold=0 and cnt still equal to DWELL-1.
  - hold is ignored in MANUAL.
- Reset mid-scan aborts immediately: all registers take reset values, and the next state is MANUAL regardless of mode.
- cnt width is $clog2(DWELL) bits, minimum 1. cur_sel increments modulo N_CH, never modulo 2^SEL_W.

Test Plan (N_CH=4, WIDTH=4, DWELL=3, channels = 1,2,3,4 unless stated):
- Reset, then mode=0 with sel=0,1,2,3 each held 3 cycles → out = 1,2,3,4, each 1 cycle after sel. ch_change pulses at each change. out=0 and cur_sel=0 during reset.
- mode=1 from cur_sel=0, hold=0, 14 cycles → out sequence 1,1,1,2,2,2,3,3,3,4,4,4,1,1. wrap pulses once, on the cycle after 4→1.
- Auto mode with hold=1 asserted during channel 2's last dwell cycle for 5 cycles → out stays 2 for 5 extra cycles, then 3 one cycle after hold drops. Changing channel 2's data to 9 during hold gives out=9 one cycle later.
- Rerun with N_CH=3: mode=0, sel=1 then sel=3 → out=2 and stays 2, cur_sel=1, sel_err one-cycle pulse, no ch_change.
- Rerun with DWELL=1: mode=1 → out = 1,2,3,4,1 on consecutive cycles; wrap every 4th cycle. Manual→auto from sel=2 → scan starts at 3, not 1.
- reset asserted mid-scan at cur_sel=2 with mode held 1 → next cycle out=0, cur_sel=0, no pulses. After release, state is MANUAL-entry then SCAN, with cnt restarting at 0.
